imem_loader: RTL

Boot-time writer for the instruction memory. It accepts a byte stream (for example from a UART receiver) using a valid/ready handshake and assembles little-endian 32-bit words. Each word is written through the instruction memory's synchronous write port at consecutive word-aligned byte addresses. While a load is in progress the block holds the core in reset, and it releases the core once the image is complete.

---
 rtl/imem_loader_if.sv | 46 ++++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// ----------------------------------------------------------------------------
// imem_loader_if
//
// Bundles the boot byte stream and the instruction-memory write port used by
// imem_loader.
//
//   in_valid   source -> loader   a byte is offered on in_data
//   in_data    source -> loader   the offered byte
//   in_ready   loader -> source   the loader can take a byte this cycle
//   imem_we    loader -> memory   one-cycle write strobe
//   imem_addr  loader -> memory   word-aligned byte address
//   imem_wdata loader -> memory   32-bit write data
//
// Handshake: a byte moves on a rising edge where in_valid && in_ready are both
// high. The source keeps in_valid/in_data stable until that edge. in_ready
// never looks at in_valid, so the source may raise valid at any time and the
// loader may drop ready at any time.
//
// Modports: master is the stream source / memory side, slave is the loader.
// ----------------------------------------------------------------------------
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction memory writer. Receives a byte stream, reads a 32-bit
// little-endian word count N, then assembles N little-endian words and writes
// them to consecutive word addresses starting at 0. The core is held in reset
// (cpu_hold=1) until the image has been written completely.
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   start         one-cycle pulse, (re)arms a load from IDLE, DONE or ERR
//   bus           stream input and memory write port (imem_loader_if.slave)
//   cpu_hold      1 = keep the core in reset
//   busy          1 while reading the header, payload, or writing
//   done          image complete
//   error         header asked for more words than MEM_WORDS
//   words_loaded  words written in the current load
//   dbg_state     current FSM state encoding, for observation
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int MEM_WORDS  = 1024,
    parameter bit AUTO_START = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_loaded,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam state_t RESET_STATE = AUTO_START ? S_LEN : S_IDLE;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;       // byte position within the current word
    logic [31:0] len_q, len_d;       // word count N from the header
    logic [31:0] word_q, word_d;     // payload word shift register
    logic [31:0] addr_q, addr_d;
    logic [15:0] words_q, words_d;

    logic        in_ready_int;
    logic        accept;
    logic [31:0] len_shift;
    logic [31:0] word_shift;

    // Ready is a pure state decode so the source sees no loop through valid.
    assign in_ready_int = (state_q == S_LEN) || (state_q == S_DATA);
    assign accept       = bus.in_valid && in_ready_int;

    // Little-endian assembly: each new byte enters at the top and the first
    // byte ends up in bits [7:0] after four shifts.
    assign len_shift  = {bus.in_data, len_q[31:8]};
    assign word_shift = {bus.in_data, word_q[31:8]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        word_d  = word_q;
        addr_d  = addr_q;
        words_d = words_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    cnt_d   = 2'd0;
                    len_d   = 32'd0;
                    addr_d  = 32'd0;
                    words_d = 16'd0;
                end
            end

            S_LEN: begin
                if (accept) begin
                    len_d = len_shift;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (len_shift == 32'd0) begin
                            state_d = S_DONE;
                        end else if (len_shift > 32'(MEM_WORDS)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    word_d = word_shift;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                addr_d  = addr_q + 32'd4;
                words_d = words_q + 16'd1;
                if ((32'(words_q) + 32'd1) == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= 2'd0;
            len_q   <= 32'd0;
            word_q  <= 32'd0;
            addr_q  <= 32'd0;
            words_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            words_q <= words_d;
        end
    end

    // The write strobe is a decode of WRITE; data and address come straight
    // from flops, so nothing here depends combinationally on the stream.
    assign bus.in_ready   = in_ready_int;
    assign bus.imem_we    = (state_q == S_WRITE);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = word_q;

    assign cpu_hold     = (state_q != S_DONE);
    assign busy         = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign words_loaded = words_q;
    assign dbg_state    = state_q;

endmodule
